// File: rtl/sensors_pkg.sv
// Shared definitions for the sensor aggregator slice.
//   agg_state_e : aggregator FSM state encoding
//   reading_t   : one sensor reading at the default reading width
//   sum_width   : width of the running sum for a channel count / reading width
//   cnt_width   : width of the active-channel count
//   idx_width   : width of the scan index
package sensors_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DIVIDE,
        ST_DONE
    } agg_state_e;

    localparam int unsigned READING_W = 8;
    typedef logic [READING_W-1:0] reading_t;

    // A single channel still needs one spare bit so the sum is always wider
    // than a reading and the divider quotient path stays uniform.
    function automatic int unsigned sum_width(input int unsigned nr, input int unsigned dw);
        return (nr <= 1) ? dw + 1 : dw + $clog2(nr);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned nr);
        return $clog2(nr + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned nr);
        return (nr <= 1) ? 1 : $clog2(nr);
    endfunction

endpackage

// File: rtl/sensors_div_serial.sv
// Serial restoring divider, one quotient bit per cycle, MSB first.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   start     : load dividend/divisor and begin (SUM_W steps follow)
//   dividend  : SUM_W-bit numerator
//   divisor   : CNT_W-bit non-zero denominator
//   done      : high during the cycle whose edge retires the last step
//   quotient  : low DATA_W bits of the result, valid while done is high
module sensors_div_serial #(
    parameter int unsigned SUM_W  = 11,
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SUM_W-1:0]  dividend,
    input  logic [CNT_W-1:0]  divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient
);

    localparam int unsigned STEP_W = $clog2(SUM_W + 1);

    logic [SUM_W-1:0]  quo_q;
    logic [SUM_W-1:0]  quo_nx;
    logic [CNT_W-1:0]  rem_q;
    logic [CNT_W-1:0]  rem_nx;
    logic [CNT_W-1:0]  div_q;
    logic [STEP_W-1:0] step_q;
    logic [CNT_W:0]    partial;
    logic [CNT_W:0]    diff;
    logic              qbit;

    // quo_q starts as the dividend and is shifted left; quotient bits fill in
    // from the bottom as dividend bits leave from the top.
    always_comb begin
        partial = {rem_q, quo_q[SUM_W-1]};
        diff    = partial - {1'b0, div_q};
        qbit    = (partial >= {1'b0, div_q});
        rem_nx  = qbit ? diff[CNT_W-1:0] : partial[CNT_W-1:0];
        quo_nx  = {quo_q[SUM_W-2:0], qbit};
    end

    // The final quotient is presented from the step logic so the consumer can
    // capture it on the same edge that retires the last step.
    assign done     = (step_q == STEP_W'(1));
    assign quotient = quo_nx[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            step_q <= '0;
        end else if (start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            div_q  <= divisor;
            step_q <= STEP_W'(SUM_W);
        end else if (step_q != '0) begin
            quo_q  <= quo_nx;
            rem_q  <= rem_nx;
            step_q <= step_q - STEP_W'(1);
        end
    end

endmodule

// File: rtl/sensors_aggregator.sv
// Sequential sensor aggregator: snapshots NR_SENSORS readings and enables on
// start, scans one channel per cycle for sum/count/min/max, then divides for
// the floor average. Results are held on a valid/ready handshake.
// Ports:
//   clk_i, rst_i          : clock and synchronous active-high reset
//   start_i               : capture request, honoured only when idle
//   sensors_data_i        : packed readings, channel k at [k*DATA_W +: DATA_W]
//   sensors_en_i          : per-channel enables
//   busy_o                : operation in flight or result awaiting acceptance
//   result_valid_o        : results valid, held until result_ready_i
//   result_ready_i        : consumer accepts results
//   temp_sum_o            : sum of enabled readings
//   nr_active_sensors_o   : number of enabled channels
//   temp_min_o/temp_max_o : min/max over enabled channels
//   temp_avg_o            : floor(sum / count)
//   none_active_o         : no channel enabled
module sensors_aggregator
    import sensors_pkg::*;
#(
    parameter int unsigned NR_SENSORS = 5,
    parameter int unsigned DATA_W     = 8,
    localparam int unsigned SUM_W     = sum_width(NR_SENSORS, DATA_W),
    localparam int unsigned CNT_W     = cnt_width(NR_SENSORS)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [NR_SENSORS*DATA_W-1:0] sensors_data_i,
    input  logic [NR_SENSORS-1:0]        sensors_en_i,
    output logic                         busy_o,
    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    output logic [SUM_W-1:0]             temp_sum_o,
    output logic [CNT_W-1:0]             nr_active_sensors_o,
    output logic [DATA_W-1:0]            temp_min_o,
    output logic [DATA_W-1:0]            temp_max_o,
    output logic [DATA_W-1:0]            temp_avg_o,
    output logic                         none_active_o
);

    localparam int unsigned IDX_W = idx_width(NR_SENSORS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_SENSORS - 1);

    agg_state_e                   state_q;
    logic [NR_SENSORS*DATA_W-1:0] data_q;
    logic [NR_SENSORS-1:0]        en_q;
    logic [IDX_W-1:0]             idx_q;
    logic [SUM_W-1:0]             sum_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [DATA_W-1:0]            min_q;
    logic [DATA_W-1:0]            max_q;

    logic [DATA_W-1:0] chan;
    logic              chan_en;
    logic [SUM_W-1:0]  sum_nx;
    logic [CNT_W-1:0]  cnt_nx;
    logic [DATA_W-1:0] min_nx;
    logic [DATA_W-1:0] max_nx;
    logic              scan_last;
    logic              div_start;
    logic              div_done;
    logic [DATA_W-1:0] div_quotient;

    // The snapshot is shifted down each scan cycle, so the channel under
    // inspection is always the lowest slot rather than a variable slice.
    always_comb begin
        chan      = data_q[DATA_W-1:0];
        chan_en   = en_q[0];
        sum_nx    = sum_q;
        cnt_nx    = cnt_q;
        min_nx    = min_q;
        max_nx    = max_q;
        if (chan_en) begin
            sum_nx = sum_q + SUM_W'(chan);
            cnt_nx = cnt_q + CNT_W'(1);
            if (chan < min_q) min_nx = chan;
            if (chan > max_q) max_nx = chan;
        end
        scan_last = (state_q == ST_SCAN) && (idx_q == LAST_IDX);
        div_start = scan_last && (cnt_nx != '0);
    end

    sensors_div_serial #(
        .SUM_W  (SUM_W),
        .CNT_W  (CNT_W),
        .DATA_W (DATA_W)
    ) u_div (
        .clk      (clk_i),
        .rst      (rst_i),
        .start    (div_start),
        .dividend (sum_nx),
        .divisor  (cnt_nx),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q             <= ST_IDLE;
            data_q              <= '0;
            en_q                <= '0;
            idx_q               <= '0;
            sum_q               <= '0;
            cnt_q               <= '0;
            min_q               <= '0;
            max_q               <= '0;
            busy_o              <= 1'b0;
            result_valid_o      <= 1'b0;
            temp_sum_o          <= '0;
            nr_active_sensors_o <= '0;
            temp_min_o          <= '0;
            temp_max_o          <= '0;
            temp_avg_o          <= '0;
            none_active_o       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        data_q  <= sensors_data_i;
                        en_q    <= sensors_en_i;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        min_q   <= '1;
                        max_q   <= '0;
                        busy_o  <= 1'b1;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    data_q <= data_q >> DATA_W;
                    en_q   <= en_q >> 1;
                    idx_q  <= idx_q + IDX_W'(1);
                    sum_q  <= sum_nx;
                    cnt_q  <= cnt_nx;
                    min_q  <= min_nx;
                    max_q  <= max_nx;
                    if (scan_last) begin
                        if (cnt_nx != '0) begin
                            state_q <= ST_DIVIDE;
                        end else begin
                            temp_sum_o          <= '0;
                            nr_active_sensors_o <= '0;
                            temp_min_o          <= '0;
                            temp_max_o          <= '0;
                            temp_avg_o          <= '0;
                            none_active_o       <= 1'b1;
                            result_valid_o      <= 1'b1;
                            state_q             <= ST_DONE;
                        end
                    end
                end
                ST_DIVIDE: begin
                    if (div_done) begin
                        temp_sum_o          <= sum_q;
                        nr_active_sensors_o <= cnt_q;
                        temp_min_o          <= min_q;
                        temp_max_o          <= max_q;
                        temp_avg_o          <= div_quotient;
                        none_active_o       <= 1'b0;
                        result_valid_o      <= 1'b1;
                        state_q             <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        busy_o         <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sensors_aggregator.md
# sensors_aggregator

Parametrised, sequential successor to the combinational sensor-sum front end. The block snapshots `NR_SENSORS` sensor readings and their enables on a start request. It scans them one channel per cycle to build the sum, active count, minimum and maximum, then computes the floor average with a serial divider. It sits between the sensor input bus and the temperature monitoring/alarm logic, and returns its results through a valid/ready handshake.

## Interface

Parameters:
- `NR_SENSORS`, default 5: number of sensor channels (≥1).
- `DATA_W`, default 8: width of one unsigned sensor reading.
- Derived, not overridable: `SUM_W = DATA_W + $clog2(NR_SENSORS)` (minimum `DATA_W+1`), `CNT_W = $clog2(NR_SENSORS+1)`.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: capture request; accepted only in IDLE.
- `sensors_data_i` in `NR_SENSORS*DATA_W`: channel k is bits `[k*DATA_W +: DATA_W]`.
- `sensors_en_i` in `NR_SENSORS`: bit k enables channel k.
- `busy_o` out 1: high whenever the state is not IDLE.
- `result_valid_o` out 1: results valid; held until accepted.
- `result_ready_i` in 1: consumer accepts results.
- `temp_sum_o` out `SUM_W`: sum of enabled readings.
- `nr_active_sensors_o` out `CNT_W`: number of enabled channels.
- `temp_min_o`, `temp_max_o` out `DATA_W`: min/max over enabled channels.
- `temp_avg_o` out `DATA_W`: floor(sum / count).
- `none_active_o` out 1: no channel enabled.

## Operation

- FSM states: IDLE, SCAN, DIVIDE, DONE.
- **IDLE**, `start_i`=1 → register data and enables, clear accumulators, go to SCAN. Accumulator clear values: sum=0, cnt=0, min=all-ones, max=0, idx=0.
- **SCAN**: each cycle handles channel `idx`. If enabled: sum += data, cnt += 1, min/max updated with unsigned compares. Then idx += 1.
- **SCAN exit**: after idx = `NR_SENSORS-1`, go to DIVIDE if cnt ≠ 0. Otherwise go straight to DONE with avg=min=max=0 and `none_active_o`=1.
- **DIVIDE**: restoring division of sum by cnt, one quotient bit per cycle, `SUM_W` cycles, MSB first. The quotient always fits in `DATA_W` because avg ≤ max. The low `DATA_W` bits go to `temp_avg_o`. Then go to DONE.
- **DONE**: `result_valid_o`=1. On `result_ready_i`=1 go to IDLE. A `start_i` in the same cycle is ignored.
- **Output registers**: load on entry to DONE. They hold their values after the handshake until the next result loads. Arithmetic never overflows: `SUM_W` covers `NR_SENSORS*(2^DATA_W-1)`.
- **Snapshot**: input changes after the start cycle have no effect on the operation in flight.
- **`start_i` outside IDLE**: ignored, not queued.
- **Reset**: `rst_i` in any state, including mid-SCAN or mid-DIVIDE, forces IDLE and drops the in-flight result. All outputs reset to 0: `busy_o`, `result_valid_o`, all result ports, `none_active_o`.

## Timing

- Call the edge that samples `start_i` in IDLE E0. `busy_o` is high from E0.
- With ≥1 channel enabled, `result_valid_o` rises after edge E(`NR_SENSORS`+`SUM_W`). Defaults: E16.
- With no channel enabled, `result_valid_o` rises after edge E(`NR_SENSORS`). Defaults: E5.
- The handshake completes on the edge where `result_valid_o` and `result_ready_i` are both 1. `result_valid_o` and `busy_o` fall after that edge. The next start is accepted one cycle later at the earliest.
- There is no combinational path from any input to any output. Every output is registered.

## Structure

- Package `sensors_pkg` holds the FSM state enum, the `SUM_W`/`CNT_W` width helper functions and the shared reading type.
- Sub-module `sensors_div_serial` holds the restoring divider. Its interface is `start`/`done`, dividend `SUM_W`, divisor `CNT_W`, quotient `DATA_W`, parameterised on the same widths.
- The aggregator holds the FSM, the snapshot registers, the scan index and the min/max/sum/count datapath.

## Test plan

- All-enabled default case: data 10,20,30,40,50, en=5'b11111 → sum 150, cnt 5, min 10, max 50, avg 30. Valid after E16.
- Partial enable with max readings: all readings 255, en=5'b10101 → sum 765, cnt 3, min 255, max 255, avg 255. No overflow.
- None enabled: en=0 → sum 0, cnt 0, min/max/avg 0, `none_active_o`=1. Valid after E5.
- Backpressure and start blocking: hold `result_ready_i`=0 for 10 cycles and pulse `start_i` during SCAN and DONE. Required: outputs stable, starts ignored, exactly one handshake.
- Reset mid-SCAN: assert `rst_i` at E2 → all outputs 0 next cycle and state IDLE. A fresh start then gives the correct result.
- Non-default parameters (`NR_SENSORS`=8, `DATA_W`=12): run 1000 random data/enable vectors against a reference model, with floor check. Example: data 7 and 8, two channels enabled → avg 7.
